// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
// Load/store initiator that sits between the EX stage and a multi-cycle data memory.
// It accepts one instruction at a time. LW/SW become a valid/ready request. A load then
// waits for its response, and the writeback value is presented with a one-cycle strobe.
// A sticky error flag is raised when the memory fails to make progress within TIMEOUT
// cycles of a REQ or WAIT phase.
//
// State table:
//   state | meaning
//   IDLE  | ready for a new instruction; non-memory ops write back from here
//   REQ   | mem_req_valid high, waiting for mem_req_ready
//   WAIT  | load issued, waiting for mem_rsp_valid
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   in_valid, Ins       instruction from EX (op = Ins[31:26])
//   Result, Rdata2      ALU result (word address for LW/SW), store data
//   nextPC              return address for JAL/JALR
//   stall               upstream hold (decoded from state)
//   Wdata, wb_valid     writeback value and its one-cycle strobe
//   err                 sticky timeout flag
//   mem_req_valid/ready request handshake (mem_req_valid decoded from state)
//   mem_we, mem_addr, mem_wdata  request payload, stable while REQ
//   mem_rsp_valid, mem_rdata     load response
module dm_access_ctrl #(
  parameter int         TIMEOUT = 16,
  parameter logic [5:0] OP_LW   = 6'h23,
  parameter logic [5:0] OP_SW   = 6'h2b,
  parameter logic [5:0] OP_JAL  = 6'h03,
  parameter logic [5:0] OP_JALR = 6'h13
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  input  logic [31:0] nextPC,
  output logic        stall,
  output logic [31:0] Wdata,
  output logic        wb_valid,
  output logic        err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Down-counter loaded with TIMEOUT-1 on entry to REQ/WAIT. Reaching zero without
  // progress means TIMEOUT cycles have been spent in the phase.
  localparam logic [7:0] TC_LOAD = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [5:0] op;
  logic       accept;
  logic       is_mem;
  logic       is_jump;
  logic       expire;
  logic       unused_ins;

  assign op         = Ins[31:26];
  assign unused_ins = ^Ins[25:0];
  assign accept     = in_valid && (state == S_IDLE);
  assign is_mem     = (op == OP_LW) || (op == OP_SW);
  assign is_jump    = (op == OP_JAL) || (op == OP_JALR);
  assign expire     = (cnt == 8'd0);

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; a progress event takes priority over expiry
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mem) state_nxt = S_REQ;
      S_REQ: begin
        if (mem_req_ready) state_nxt = mem_we ? S_IDLE : S_WAIT;
        else if (expire)   state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (mem_rsp_valid) state_nxt = S_IDLE;
        else if (expire)   state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    if (state != S_IDLE) stall = 1'b1;
    if (state == S_REQ)  mem_req_valid = 1'b1;
  end

  // registered outputs and timeout counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      Wdata     <= '0;
      wb_valid  <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mem) begin
              mem_addr  <= Result;
              mem_wdata <= Rdata2;
              mem_we    <= (op == OP_SW);
              cnt       <= TC_LOAD;
            end else begin
              Wdata    <= is_jump ? nextPC : Result;
              wb_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            cnt <= TC_LOAD;
          end else if (expire) begin
            err <= 1'b1;
            if (!mem_we) begin
              Wdata    <= '0;
              wb_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            Wdata    <= mem_rdata;
            wb_valid <= 1'b1;
          end else if (expire) begin
            err      <= 1'b1;
            Wdata    <= '0;
            wb_valid <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl (TIMEOUT = 4).
module tb_dm_access_ctrl;

  localparam int         TO      = 4;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_JALR = 6'h13;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] Ins = '0, Result = '0, Rdata2 = '0, nextPC = '0;
  logic        stall, wb_valid, err, mem_req_valid, mem_we;
  logic [31:0] Wdata, mem_addr, mem_wdata;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  dm_access_ctrl #(
    .TIMEOUT(TO), .OP_LW(OP_LW), .OP_SW(OP_SW), .OP_JAL(OP_JAL), .OP_JALR(OP_JALR)
  ) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .Ins(Ins), .Result(Result),
    .Rdata2(Rdata2), .nextPC(nextPC), .stall(stall), .Wdata(Wdata),
    .wb_valid(wb_valid), .err(err), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] res, d2, npc, rdat;
    int          rq, rs;        // ready delay in REQ, response delay in WAIT
    int          e_stall, e_req, e_wb;
    logic [31:0] e_val;
    logic        e_err;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [5:0] op, input logic [31:0] res, d2, npc, rdat,
                              input int rq, rs, e_stall, e_req, e_wb,
                              input logic [31:0] e_val, input logic e_err);
    txn_t t;
    t.op = op; t.res = res; t.d2 = d2; t.npc = npc; t.rdat = rdat;
    t.rq = rq; t.rs = rs; t.e_stall = e_stall; t.e_req = e_req; t.e_wb = e_wb;
    t.e_val = e_val; t.e_err = e_err;
    return t;
  endfunction

  // Transaction-level reference: cycles spent, writeback outcome and sticky error.
  function automatic txn_t model(input txn_t t, input logic err_in);
    txn_t r = t;
    r.e_err = err_in; r.e_wb = 0; r.e_val = '0; r.e_req = 0;
    if (t.op != OP_LW && t.op != OP_SW) begin
      r.e_stall = 0;
      r.e_wb    = 1;
      r.e_val   = (t.op == OP_JAL || t.op == OP_JALR) ? t.npc : t.res;
    end else if (t.rq >= TO) begin
      r.e_stall = TO; r.e_req = TO; r.e_err = 1'b1;
      r.e_wb    = (t.op == OP_LW) ? 1 : 0;
    end else begin
      r.e_req = t.rq + 1;
      if (t.op == OP_SW) r.e_stall = t.rq + 1;
      else if (t.rs >= TO) begin
        r.e_stall = t.rq + 1 + TO; r.e_wb = 1; r.e_err = 1'b1;
      end else begin
        r.e_stall = t.rq + 2 + t.rs; r.e_wb = 1; r.e_val = t.rdat;
      end
    end
    return r;
  endfunction

  // Called #1 after an edge with the DUT idle. The memory side follows a fixed schedule
  // relative to acceptance; rsp noise is injected during REQ and must be ignored.
  task automatic run_txn(input string tag, input txn_t t);
    int          n_stall = 0, n_wb = 0, n_req = 0;
    logic [31:0] wb_val = '0;
    bit          req_bad = 0, done = 0;
    Ins = {t.op, 26'($urandom)}; Result = t.res; Rdata2 = t.d2; nextPC = t.npc;
    mem_rdata = t.rdat; in_valid = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'($urandom);
    for (int k = 1; k <= 2 * TO + 6 && !done; k++) begin
      @(posedge CLK); #1;
      if (stall) n_stall++;
      if (wb_valid) begin n_wb++; wb_val = Wdata; end
      if (mem_req_valid) begin
        n_req++;
        if (mem_addr !== t.res || mem_wdata !== t.d2 || mem_we !== (t.op == OP_SW)) req_bad = 1;
      end
      if (!stall) done = 1;
      else begin
        in_valid      = 1'($urandom);
        mem_req_ready = (k == 1 + t.rq);
        mem_rsp_valid = (k == 2 + t.rq + t.rs) || ((k <= 1 + t.rq) && 1'($urandom));
      end
    end
    in_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    chk({tag, " done"},     32'(done), 32'd1);
    chk({tag, " stall"},    n_stall, t.e_stall);
    chk({tag, " req_cyc"},  n_req, t.e_req);
    chk({tag, " req_fld"},  32'(req_bad), 32'd0);
    chk({tag, " wb_cnt"},   n_wb, t.e_wb);
    if (t.e_wb != 0) chk({tag, " wdata"}, wb_val, t.e_val);
    chk({tag, " err"},      32'(err), 32'(t.e_err));
  endtask

  txn_t tbl[10];
  txn_t rt;
  logic mdl_err;
  logic [5:0] ops[6];

  initial begin
    tbl[0] = mk(OP_JAL,  32'd5,      32'h0,    32'h40, 32'h0,    0, 0, 0, 0, 1, 32'h40,   1'b0);
    tbl[1] = mk(OP_JALR, 32'h11,     32'h0,    32'h88, 32'h0,    0, 0, 0, 0, 1, 32'h88,   1'b0);
    tbl[2] = mk(6'h00,   32'h1234,   32'h0,    32'h99, 32'h0,    0, 0, 0, 0, 1, 32'h1234, 1'b0);
    tbl[3] = mk(OP_SW,   32'd10,     32'hCAFE, 32'h0,  32'h0,    3, 0, 4, 4, 0, 32'h0,    1'b0);
    tbl[4] = mk(OP_LW,   32'd7,      32'h0,    32'h0,  32'd777,  0, 1, 3, 1, 1, 32'd777,  1'b0);
    tbl[5] = mk(OP_LW,   32'h20,     32'h0,    32'h0,  32'hABCD, 3, 3, 8, 4, 1, 32'hABCD, 1'b0);
    tbl[6] = mk(OP_LW,   32'd1,      32'h0,    32'h0,  32'h5A5A, 0, 4, 5, 1, 1, 32'h0,    1'b1);
    tbl[7] = mk(OP_LW,   32'd2,      32'h0,    32'h0,  32'h55,   0, 0, 2, 1, 1, 32'h55,   1'b1);
    tbl[8] = mk(OP_SW,   32'd3,      32'h77,   32'h0,  32'h0,    4, 0, 4, 4, 0, 32'h0,    1'b1);
    tbl[9] = mk(OP_LW,   32'd4,      32'h0,    32'h0,  32'h66,   5, 0, 4, 4, 1, 32'h0,    1'b1);

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst Wdata", Wdata, 32'h0);
    chk("rst flags", {27'h0, stall, wb_valid, err, mem_req_valid, mem_we}, 32'h0);
    chk("rst addr",  mem_addr, 32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 10; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);

    // reset while a load sits in WAIT, then a late response
    Ins = {OP_LW, 26'h0}; Result = 32'h77; Rdata2 = 32'h5; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge CLK); #1;
    mem_req_ready = 1'b0;
    chk("mid stall", 32'(stall && !mem_req_valid), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("mid Wdata", Wdata, 32'h0);
    chk("mid flags", {27'h0, stall, wb_valid, err, mem_req_valid, mem_we}, 32'h0);
    chk("mid addr",  mem_addr, 32'h0);
    chk("mid wdata", mem_wdata, 32'h0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h999;
    @(posedge CLK); #1;
    mem_rsp_valid = 1'b0;
    chk("late rsp wb",    32'(wb_valid), 32'd0);
    chk("late rsp stall", 32'(stall), 32'd0);

    // randomized transactions against the transaction-level model
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_JAL; ops[3] = OP_JALR;
    ops[4] = 6'h00; ops[5] = 6'h08;
    mdl_err = 1'b0;
    for (int n = 0; n < 60; n++) begin
      rt.op   = ops[$urandom_range(0, 5)];
      rt.res  = $urandom; rt.d2 = $urandom; rt.npc = $urandom; rt.rdat = $urandom;
      rt.rq   = $urandom_range(0, 5);
      rt.rs   = $urandom_range(0, 5);
      rt      = model(rt, mdl_err);
      mdl_err = rt.e_err;
      run_txn($sformatf("rnd%0d", n), rt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
